// File: rtl/rob_retire.sv
// Reorder buffer control: allocates renamed instructions, marks completions from
// the CDB, retires in program order and squashes younger entries on a mispredict.
module rob_retire #(
  parameter int ROB_SIZE        = 32,
  parameter int ROB_SIZE_CLOG   = 5,
  parameter int ISSUE_WIDTH_MAX = 2,
  parameter int ROB_MAX_RETIRE  = 2,
  parameter int NUM_CDB         = 2,
  parameter int SRC_LEN         = 5,
  parameter int OPCODE_LEN      = 7,
  parameter logic [OPCODE_LEN-1:0] SB_TYPE = 7'b1100011
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [ISSUE_WIDTH_MAX-1:0]                      instr_val_id,
  input  logic [ISSUE_WIDTH_MAX-1:0][OPCODE_LEN-1:0]      opcode_id,
  input  logic [ISSUE_WIDTH_MAX-1:0][SRC_LEN-1:0]         rd_id,
  input  logic [NUM_CDB-1:0]                              cdb_val,
  input  logic [NUM_CDB-1:0][ROB_SIZE_CLOG-1:0]           cdb_robid,
  input  logic [NUM_CDB-1:0]                              cdb_mispredict,
  output logic [ROB_SIZE_CLOG-1:0]                        rob_is_ptr,
  output logic                                            rob_full,
  output logic                                            rob_empty,
  output logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]          rd_ret,
  output logic [ROB_MAX_RETIRE-1:0]                       val_ret,
  output logic [ROB_MAX_RETIRE-1:0]                       branch_ret,
  output logic [ROB_SIZE_CLOG-1:0]                        mispredict_tag_id,
  output logic                                            branch_clear_id
);

  localparam int CW = ROB_SIZE_CLOG + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(ROB_SIZE - ISSUE_WIDTH_MAX);

  logic [ROB_SIZE_CLOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic [ROB_SIZE-1:0]      valid_q, valid_d, done_q, done_d, mispred_q, mispred_d;
  logic [ROB_SIZE-1:0]      is_branch_q, is_branch_d;
  logic [ROB_SIZE-1:0][SRC_LEN-1:0] rd_q, rd_d;

  logic                     full;
  logic [ISSUE_WIDTH_MAX-1:0] accept;
  logic [ISSUE_WIDTH_MAX-1:0][ROB_SIZE_CLOG-1:0] alloc_idx;
  logic [ROB_SIZE_CLOG-1:0] alloc_end;
  logic [CW-1:0]            n_acc, n_ret;
  logic [ROB_MAX_RETIRE-1:0] ret;
  logic [ROB_MAX_RETIRE-1:0][ROB_SIZE_CLOG-1:0] ret_idx;
  logic                     ret_go;
  logic                     flush;
  logic [ROB_SIZE_CLOG-1:0] flush_tag;

  logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0] rd_ret_q, rd_ret_d;
  logic [ROB_MAX_RETIRE-1:0] val_ret_q, val_ret_d, branch_ret_q, branch_ret_d;
  logic [ROB_SIZE_CLOG-1:0] tag_q, tag_d;
  logic                     clear_q, clear_d;

  assign full   = (count_q > FULL_LVL);
  assign accept = instr_val_id & ~{ISSUE_WIDTH_MAX{full}};

  // Accepted slots are packed onto consecutive robids starting at tail.
  always_comb begin
    alloc_idx = '0;
    alloc_end = tail_q;
    n_acc     = '0;
    for (int s = 0; s < ISSUE_WIDTH_MAX; s++) begin
      alloc_idx[s] = alloc_end;
      if (accept[s]) begin
        alloc_end = alloc_end + ROB_SIZE_CLOG'(1);
        n_acc     = n_acc + CW'(1);
      end
    end
  end

  // In-order retire; the first mispredicted entry retires and ends the group.
  always_comb begin
    ret       = '0;
    ret_idx   = '0;
    n_ret     = '0;
    flush     = 1'b0;
    flush_tag = '0;
    ret_go    = 1'b1;
    for (int r = 0; r < ROB_MAX_RETIRE; r++) begin
      ret_idx[r] = head_q + ROB_SIZE_CLOG'(r);
      if (ret_go && valid_q[ret_idx[r]] && done_q[ret_idx[r]]) begin
        ret[r] = 1'b1;
        n_ret  = n_ret + CW'(1);
        if (mispred_q[ret_idx[r]]) begin
          flush     = 1'b1;
          flush_tag = ret_idx[r];
          ret_go    = 1'b0;
        end
      end else begin
        ret_go = 1'b0;
      end
    end
  end

  always_comb begin
    valid_d     = valid_q;
    done_d      = done_q;
    mispred_d   = mispred_q;
    is_branch_d = is_branch_q;
    rd_d        = rd_q;
    head_d      = head_q + n_ret[ROB_SIZE_CLOG-1:0];
    tail_d      = alloc_end;
    count_d     = count_q + n_acc - n_ret;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (cdb_val[c] && valid_q[cdb_robid[c]]) begin
        done_d[cdb_robid[c]]    = 1'b1;
        mispred_d[cdb_robid[c]] = mispred_d[cdb_robid[c]] | cdb_mispredict[c];
      end
    end
    for (int r = 0; r < ROB_MAX_RETIRE; r++) begin
      if (ret[r]) begin
        valid_d[ret_idx[r]]   = 1'b0;
        done_d[ret_idx[r]]    = 1'b0;
        mispred_d[ret_idx[r]] = 1'b0;
      end
    end
    if (flush) begin
      valid_d   = '0;
      done_d    = '0;
      mispred_d = '0;
      head_d    = flush_tag + ROB_SIZE_CLOG'(1);
      tail_d    = flush_tag + ROB_SIZE_CLOG'(1);
      count_d   = '0;
    end else begin
      for (int s = 0; s < ISSUE_WIDTH_MAX; s++) begin
        if (accept[s]) begin
          valid_d[alloc_idx[s]]     = 1'b1;
          done_d[alloc_idx[s]]      = 1'b0;
          mispred_d[alloc_idx[s]]   = 1'b0;
          is_branch_d[alloc_idx[s]] = (opcode_id[s] == SB_TYPE);
          rd_d[alloc_idx[s]]        = rd_id[s];
        end
      end
    end
  end

  always_comb begin
    val_ret_d    = ret;
    rd_ret_d     = '0;
    branch_ret_d = '0;
    for (int r = 0; r < ROB_MAX_RETIRE; r++) begin
      if (ret[r]) begin
        rd_ret_d[r]     = rd_q[ret_idx[r]];
        branch_ret_d[r] = is_branch_q[ret_idx[r]];
      end
    end
    clear_d = flush;
    tag_d   = flush ? flush_tag : tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      done_q       <= '0;
      mispred_q    <= '0;
      val_ret_q    <= '0;
      rd_ret_q     <= '0;
      branch_ret_q <= '0;
      clear_q      <= 1'b0;
      tag_q        <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      mispred_q    <= mispred_d;
      val_ret_q    <= val_ret_d;
      rd_ret_q     <= rd_ret_d;
      branch_ret_q <= branch_ret_d;
      clear_q      <= clear_d;
      tag_q        <= tag_d;
    end
  end

  // Payload fields are only read through valid entries, so they carry no reset.
  always_ff @(posedge clk) begin
    is_branch_q <= is_branch_d;
    rd_q        <= rd_d;
  end

  assign rob_is_ptr        = tail_q;
  assign rob_full          = full;
  assign rob_empty         = (count_q == '0);
  assign rd_ret            = rd_ret_q;
  assign val_ret           = val_ret_q;
  assign branch_ret        = branch_ret_q;
  assign mispredict_tag_id = tag_q;
  assign branch_clear_id   = clear_q;

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: reset, single path, in-order blocking, full,
// mispredict recovery and pointer wrap-around.
module tb_rob_retire;

  localparam logic [6:0] SB = 7'b1100011;

  logic            clk;
  logic            rst;
  logic [1:0]      instr_val_id;
  logic [1:0][6:0] opcode_id;
  logic [1:0][4:0] rd_id;
  logic [1:0]      cdb_val;
  logic [1:0][4:0] cdb_robid;
  logic [1:0]      cdb_mispredict;
  logic [4:0]      rob_is_ptr;
  logic            rob_full;
  logic            rob_empty;
  logic [1:0][4:0] rd_ret;
  logic [1:0]      val_ret;
  logic [1:0]      branch_ret;
  logic [4:0]      mispredict_tag_id;
  logic            branch_clear_id;

  int errors = 0;
  int checks = 0;

  rob_retire dut (
    .clk(clk), .rst(rst),
    .instr_val_id(instr_val_id), .opcode_id(opcode_id), .rd_id(rd_id),
    .cdb_val(cdb_val), .cdb_robid(cdb_robid), .cdb_mispredict(cdb_mispredict),
    .rob_is_ptr(rob_is_ptr), .rob_full(rob_full), .rob_empty(rob_empty),
    .rd_ret(rd_ret), .val_ret(val_ret), .branch_ret(branch_ret),
    .mispredict_tag_id(mispredict_tag_id), .branch_clear_id(branch_clear_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_val_id   = '0;
    opcode_id      = '0;
    rd_id          = '0;
    cdb_val        = '0;
    cdb_robid      = '0;
    cdb_mispredict = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (rob_is_ptr !== 5'd0) begin errors++; $display("FAIL rst_ptr: got %0d expected 0", rob_is_ptr); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b expected 1", rob_empty); end
    checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b expected 0", rob_full); end
    checks++; if (val_ret !== 2'b00) begin errors++; $display("FAIL rst_val_ret: got %b expected 00", val_ret); end
    checks++; if (branch_clear_id !== 1'b0 || mispredict_tag_id !== 5'd0) begin errors++; $display("FAIL rst_clear: got %b/%0d expected 0/0", branch_clear_id, mispredict_tag_id); end
    rst = 1'b0;
    // Mid-operation reset wins over same-cycle allocation and completion.
    instr_val_id = 2'b11;
    tick();
    cdb_val = 2'b11; cdb_robid[0] = 5'd0; cdb_robid[1] = 5'd1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    checks++; if (rob_is_ptr !== 5'd0 || rob_empty !== 1'b1) begin errors++; $display("FAIL midrst_state: got ptr=%0d empty=%0b expected ptr=0 empty=1", rob_is_ptr, rob_empty); end
    tick();
    checks++; if (val_ret !== 2'b00) begin errors++; $display("FAIL midrst_noretire: got %b expected 00", val_ret); end
  endtask

  task automatic test_single_path();
    do_reset();
    // Completion to a not-yet-allocated entry must be ignored.
    cdb_val = 2'b01; cdb_robid[0] = 5'd0;
    tick();
    cdb_val = 2'b00;
    instr_val_id = 2'b10; rd_id[1] = 5'd5;
    tick();
    instr_val_id = 2'b00;
    checks++; if (rob_is_ptr !== 5'd1 || rob_empty !== 1'b0) begin errors++; $display("FAIL sp_alloc: got ptr=%0d empty=%0b expected ptr=1 empty=0", rob_is_ptr, rob_empty); end
    tick();
    tick();
    checks++; if (val_ret !== 2'b00) begin errors++; $display("FAIL sp_stale_cdb: got %b expected 00", val_ret); end
    cdb_val = 2'b01; cdb_robid[0] = 5'd0;
    tick();
    cdb_val = 2'b00;
    checks++; if (val_ret !== 2'b00) begin errors++; $display("FAIL sp_early: got %b expected 00", val_ret); end
    tick();
    checks++; if (val_ret !== 2'b01 || rd_ret[0] !== 5'd5 || branch_ret !== 2'b00) begin errors++; $display("FAIL sp_retire: got val=%b rd0=%0d br=%b expected val=01 rd0=5 br=00", val_ret, rd_ret[0], branch_ret); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL sp_empty: got %0b expected 1", rob_empty); end
    tick();
    checks++; if (val_ret !== 2'b00) begin errors++; $display("FAIL sp_pulse: got %b expected 00", val_ret); end
  endtask

  task automatic test_in_order();
    do_reset();
    instr_val_id = 2'b11; rd_id[0] = 5'd3; rd_id[1] = 5'd4;
    tick();
    instr_val_id = 2'b00;
    checks++; if (rob_is_ptr !== 5'd2) begin errors++; $display("FAIL io_ptr: got %0d expected 2", rob_is_ptr); end
    cdb_val = 2'b01; cdb_robid[0] = 5'd1;
    tick();
    cdb_val = 2'b00;
    tick();
    checks++; if (val_ret !== 2'b00) begin errors++; $display("FAIL io_blocked: got %b expected 00", val_ret); end
    cdb_val = 2'b10; cdb_robid[1] = 5'd0;
    tick();
    cdb_val = 2'b00;
    tick();
    checks++; if (val_ret !== 2'b11 || rd_ret[1] !== 5'd4 || rd_ret[0] !== 5'd3) begin errors++; $display("FAIL io_retire: got val=%b rd={%0d,%0d} expected val=11 rd={4,3}", val_ret, rd_ret[1], rd_ret[0]); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL io_empty: got %0b expected 1", rob_empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      instr_val_id = 2'b11;
      tick();
      if (i == 14) begin
        checks++; if (rob_full !== 1'b0 || rob_is_ptr !== 5'd30) begin errors++; $display("FAIL full_at30: got full=%0b ptr=%0d expected full=0 ptr=30", rob_full, rob_is_ptr); end
      end
    end
    checks++; if (rob_full !== 1'b1 || rob_is_ptr !== 5'd0) begin errors++; $display("FAIL full_at32: got full=%0b ptr=%0d expected full=1 ptr=0", rob_full, rob_is_ptr); end
    tick();
    checks++; if (rob_is_ptr !== 5'd0) begin errors++; $display("FAIL full_hold: got %0d expected 0", rob_is_ptr); end
    cdb_val = 2'b01; cdb_robid[0] = 5'd0;
    tick();
    cdb_val = 2'b00;
    tick();
    checks++; if (val_ret !== 2'b01 || rob_full !== 1'b1 || rob_is_ptr !== 5'd0) begin errors++; $display("FAIL full_at31: got val=%b full=%0b ptr=%0d expected val=01 full=1 ptr=0", val_ret, rob_full, rob_is_ptr); end
    cdb_val = 2'b01; cdb_robid[0] = 5'd1;
    tick();
    cdb_val = 2'b00;
    tick();
    instr_val_id = 2'b00;
    checks++; if (val_ret !== 2'b01 || rob_full !== 1'b0 || rob_is_ptr !== 5'd0) begin errors++; $display("FAIL full_release: got val=%b full=%0b ptr=%0d expected val=01 full=0 ptr=0", val_ret, rob_full, rob_is_ptr); end
  endtask

  task automatic test_mispredict();
    do_reset();
    instr_val_id = 2'b11; rd_id[0] = 5'd10; rd_id[1] = 5'd11;
    tick();
    opcode_id[0] = SB; rd_id[0] = 5'd12; rd_id[1] = 5'd13;
    tick();
    opcode_id[0] = 7'd0; rd_id[0] = 5'd14; rd_id[1] = 5'd15;
    tick();
    instr_val_id = 2'b00;
    checks++; if (rob_is_ptr !== 5'd6) begin errors++; $display("FAIL mp_ptr6: got %0d expected 6", rob_is_ptr); end
    cdb_val = 2'b11; cdb_robid[0] = 5'd0; cdb_robid[1] = 5'd1;
    tick();
    cdb_robid[0] = 5'd2; cdb_robid[1] = 5'd3; cdb_mispredict = 2'b01;
    tick();
    checks++; if (val_ret !== 2'b11 || rd_ret[1] !== 5'd11 || rd_ret[0] !== 5'd10 || branch_ret !== 2'b00 || branch_clear_id !== 1'b0) begin errors++; $display("FAIL mp_first: got val=%b rd={%0d,%0d} br=%b clr=%0b expected val=11 rd={11,10} br=00 clr=0", val_ret, rd_ret[1], rd_ret[0], branch_ret, branch_clear_id); end
    cdb_robid[0] = 5'd4; cdb_robid[1] = 5'd5; cdb_mispredict = 2'b00;
    instr_val_id = 2'b11;
    tick();
    idle_inputs();
    checks++; if (val_ret !== 2'b01 || branch_ret !== 2'b01 || rd_ret[0] !== 5'd12 || rd_ret[1] !== 5'd0) begin errors++; $display("FAIL mp_branch: got val=%b br=%b rd={%0d,%0d} expected val=01 br=01 rd={0,12}", val_ret, branch_ret, rd_ret[1], rd_ret[0]); end
    checks++; if (branch_clear_id !== 1'b1 || mispredict_tag_id !== 5'd2) begin errors++; $display("FAIL mp_clear: got clr=%0b tag=%0d expected clr=1 tag=2", branch_clear_id, mispredict_tag_id); end
    checks++; if (rob_is_ptr !== 5'd3 || rob_empty !== 1'b1) begin errors++; $display("FAIL mp_recover: got ptr=%0d empty=%0b expected ptr=3 empty=1", rob_is_ptr, rob_empty); end
    tick();
    checks++; if (branch_clear_id !== 1'b0 || val_ret !== 2'b00) begin errors++; $display("FAIL mp_pulse: got clr=%0b val=%b expected clr=0 val=00", branch_clear_id, val_ret); end
    tick();
    tick();
    checks++; if (val_ret !== 2'b00 || rob_empty !== 1'b1 || rob_is_ptr !== 5'd3) begin errors++; $display("FAIL mp_squashed: got val=%b empty=%0b ptr=%0d expected val=00 empty=1 ptr=3", val_ret, rob_empty, rob_is_ptr); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      instr_val_id = 2'b11;
      tick();
      instr_val_id = 2'b00;
      cdb_val = 2'b11; cdb_robid[0] = 5'(2 * i); cdb_robid[1] = 5'(2 * i + 1);
      tick();
      cdb_val = 2'b00;
    end
    tick();
    tick();
    checks++; if (rob_is_ptr !== 5'd30 || rob_empty !== 1'b1) begin errors++; $display("FAIL wrap_pre: got ptr=%0d empty=%0b expected ptr=30 empty=1", rob_is_ptr, rob_empty); end
    instr_val_id = 2'b11; rd_id[0] = 5'd20; rd_id[1] = 5'd21;
    tick();
    checks++; if (rob_is_ptr !== 5'd0) begin errors++; $display("FAIL wrap_ptr0: got %0d expected 0", rob_is_ptr); end
    rd_id[0] = 5'd22; rd_id[1] = 5'd23;
    tick();
    instr_val_id = 2'b00;
    checks++; if (rob_is_ptr !== 5'd2) begin errors++; $display("FAIL wrap_ptr2: got %0d expected 2", rob_is_ptr); end
    cdb_val = 2'b11; cdb_robid[0] = 5'd30; cdb_robid[1] = 5'd31;
    tick();
    cdb_robid[0] = 5'd0; cdb_robid[1] = 5'd1;
    tick();
    cdb_val = 2'b00;
    checks++; if (val_ret !== 2'b11 || rd_ret[1] !== 5'd21 || rd_ret[0] !== 5'd20) begin errors++; $display("FAIL wrap_ret_hi: got val=%b rd={%0d,%0d} expected val=11 rd={21,20}", val_ret, rd_ret[1], rd_ret[0]); end
    tick();
    checks++; if (val_ret !== 2'b11 || rd_ret[1] !== 5'd23 || rd_ret[0] !== 5'd22) begin errors++; $display("FAIL wrap_ret_lo: got val=%b rd={%0d,%0d} expected val=11 rd={23,22}", val_ret, rd_ret[1], rd_ret[0]); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %0b expected 1", rob_empty); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_path();
    test_in_order();
    test_full();
    test_mispredict();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
